// File: rtl/phase_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer_bcd
// Brief   : Washer phase timer with BCD mm:ss remaining/elapsed display,
//           pause/hold, sticky per-phase done flags and a 1-cycle done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module phase_timer_bcd #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned WASH_S    = 600,
  parameter int unsigned WATER_S   = 30,
  parameter int unsigned DEWATER_S = 300,
  parameter int unsigned ALARM_S   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_in,
  input  logic       pause,
  input  logic       count_up,
  output logic       wash,
  output logic       water,
  output logic       dewater,
  output logic       alarm,
  output logic       done_pulse,
  output logic       running,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0
);

  function automatic logic [15:0] to_bcd(input int unsigned s);
    int unsigned m;
    int unsigned x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Digit limits from the least significant digit up: 9, 5, 9, 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] == 4'd5) ? 4'd0 : v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  localparam int unsigned      c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0]  c_TICK_MAX = c_PW'(TICK_DIV - 1);

  localparam logic [15:0] c_WASH_BCD    = to_bcd(WASH_S);
  localparam logic [15:0] c_WATER_BCD   = to_bcd(WATER_S);
  localparam logic [15:0] c_DEWATER_BCD = to_bcd(DEWATER_S);
  localparam logic [15:0] c_ALARM_BCD   = to_bcd(ALARM_S);

  localparam logic [2:0] c_PH_WASH    = 3'b011;
  localparam logic [2:0] c_PH_WATER   = 3'b010;
  localparam logic [2:0] c_PH_DEWATER = 3'b110;
  localparam logic [2:0] c_PH_ALARM   = 3'b100;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_PAUSE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]      fsm_q, fsm_d;
  logic [2:0]      state_q, state_d;
  logic [c_PW-1:0] presc_q, presc_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     ela_q, ela_d;
  logic [3:0]      flag_q, flag_d;
  logic            done_q, done_d;

  logic        w_timed;
  logic        w_change;
  logic        w_count;
  logic        w_tick;
  logic        w_expire;
  logic [15:0] w_dur;

  always_comb begin
    w_timed = (state_in == c_PH_WASH) || (state_in == c_PH_WATER) ||
              (state_in == c_PH_DEWATER) || (state_in == c_PH_ALARM);
    w_dur = 16'h0000;
    case (state_in)
      c_PH_WASH:    w_dur = c_WASH_BCD;
      c_PH_WATER:   w_dur = c_WATER_BCD;
      c_PH_DEWATER: w_dur = c_DEWATER_BCD;
      c_PH_ALARM:   w_dur = c_ALARM_BCD;
      default:      w_dur = 16'h0000;
    endcase
  end

  // Reload and untimed clear take priority over counting in the same cycle.
  assign w_change = (state_in != state_q);
  assign w_count  = (fsm_q == c_RUN) && w_timed && !w_change;
  assign w_tick   = w_count && (presc_q == c_TICK_MAX);
  assign w_expire = w_tick && (rem_q == 16'h0001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= c_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (!w_timed) begin
      fsm_d = c_IDLE;
    end else if (w_change) begin
      fsm_d = pause ? c_PAUSE : c_RUN;
    end else begin
      case (fsm_q)
        c_RUN: begin
          if (w_expire)   fsm_d = c_DONE;
          else if (pause) fsm_d = c_PAUSE;
        end
        c_PAUSE: begin
          if (!pause) fsm_d = c_RUN;
        end
        default: fsm_d = fsm_q;
      endcase
    end
  end

  always_comb begin
    running = (fsm_q == c_RUN);
    {seg3, seg2, seg1, seg0} = count_up ? ela_q : rem_q;
  end

  always_comb begin
    state_d = state_in;
    presc_d = presc_q;
    rem_d   = rem_q;
    ela_d   = ela_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    if (!w_timed) begin
      presc_d = '0;
      rem_d   = '0;
      ela_d   = '0;
      flag_d  = '0;
    end else if (w_change) begin
      presc_d = '0;
      rem_d   = w_dur;
      ela_d   = '0;
      flag_d  = '0;
    end else if (w_count) begin
      if (w_tick) begin
        presc_d = '0;
        rem_d   = bcd_dec(rem_q);
        ela_d   = bcd_inc(ela_q);
        if (w_expire) begin
          done_d = 1'b1;
          flag_d = flag_q | {state_q == c_PH_WASH, state_q == c_PH_WATER,
                             state_q == c_PH_DEWATER, state_q == c_PH_ALARM};
        end
      end else begin
        presc_d = presc_q + c_PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= 3'b000;
      presc_q <= '0;
      rem_q   <= '0;
      ela_q   <= '0;
      flag_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      ela_q   <= ela_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign {wash, water, dewater, alarm} = flag_q;
  assign done_pulse = done_q;

endmodule
`default_nettype wire
